// File: rtl/wb_queue_pkg.sv
// Types and constants shared by the writeback queue and its storage.
// Widths are taken from defines.v so there is a single source of truth.
`include "defines.v"

package wb_queue_pkg;

  localparam int unsigned XLEN             = `XLEN;
  localparam int unsigned RFIDX_W          = `RFIDX_WIDTH;
  localparam int unsigned WB_DEPTH_DEFAULT = `WB_DEPTH;
  localparam int unsigned ENTRY_W          = RFIDX_W + XLEN;

  // One pending register write.
  typedef struct packed {
    logic [RFIDX_W-1:0] rd;
    logic [XLEN-1:0]    data;
  } wb_entry_t;

  // Result of a forwarding lookup.
  typedef struct packed {
    logic            hit;
    logic [XLEN-1:0] data;
  } fwd_result_t;

endpackage

// File: rtl/defines.v
// Shared build constants for the writeback path.
//   XLEN         datapath width
//   RFIDX_WIDTH  register-file index width
//   WB_DEPTH     default number of buffered pending register writes
`ifndef WB_DEFINES_V
`define WB_DEFINES_V

`define XLEN        32
`define RFIDX_WIDTH 5
`define WB_DEPTH    4

`endif

// File: rtl/wb_fifo.sv
// Circular storage for pending register writes.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (clears pointers/count)
//   push, push_rd/data  write an entry at the tail (caller guarantees not full)
//   pop                 advance the head (caller guarantees not empty)
//   head_rd/head_data   entry at the head
//   count               number of stored entries
//   head_ptr, entries   raw head pointer and storage, only when WB_FWD_EN is defined
// Macro WB_FWD_EN exposes the storage for forwarding search.
`include "defines.v"

module wb_fifo
  import wb_queue_pkg::*;
#(
  parameter int unsigned DEPTH = `WB_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [`RFIDX_WIDTH-1:0]      push_rd,
  input  logic [`XLEN-1:0]             push_data,
  input  logic                         pop,
  output logic [`RFIDX_WIDTH-1:0]      head_rd,
  output logic [`XLEN-1:0]             head_data,
`ifdef WB_FWD_EN
  output logic [$clog2(DEPTH)-1:0]     head_ptr,
  output logic [DEPTH*ENTRY_W-1:0]     entries,
`endif
  output logic [$clog2(DEPTH):0]       count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  wb_entry_t [DEPTH-1:0] mem_q;
  logic [PtrW-1:0]       head_q, tail_q;
  logic [PtrW:0]         count_q, count_d;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: only slots covered by count are ever read.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= '{rd: push_rd, data: push_data};
  end

  assign head_rd   = mem_q[head_q].rd;
  assign head_data = mem_q[head_q].data;
  assign count     = count_q;

`ifdef WB_FWD_EN
  assign head_ptr = head_q;
  assign entries  = mem_q;
`endif

endmodule

// File: rtl/wb_queue.sv
// Writeback queue: buffers completed results and retires one per cycle into the
// register file through a registered write port.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid/in_ready             result handshake from the preceding stage
//   in_rd, in_data                destination index and value (rd 0 is discarded)
//   reg_write, write_addr/data    registered regfile write port
//   pending                       entries stored, excluding the output register
//   fwd_addrK/fwd_hitK/fwd_dataK  forwarding lookups, only with WB_FWD_EN
// Macro WB_FWD_EN enables the forwarding ports and search logic.
`include "defines.v"

module wb_queue
  import wb_queue_pkg::*;
#(
  parameter int unsigned DEPTH = `WB_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [`RFIDX_WIDTH-1:0]  in_rd,
  input  logic [`XLEN-1:0]         in_data,
  output logic                     reg_write,
  output logic [`RFIDX_WIDTH-1:0]  write_addr,
  output logic [`XLEN-1:0]         write_data,
`ifdef WB_FWD_EN
  input  logic [`RFIDX_WIDTH-1:0]  fwd_addr1,
  input  logic [`RFIDX_WIDTH-1:0]  fwd_addr2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [`XLEN-1:0]         fwd_data1,
  output logic [`XLEN-1:0]         fwd_data2,
`endif
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW:0]             count;
  logic                      push, pop;
  logic [`RFIDX_WIDTH-1:0]   head_rd;
  logic [`XLEN-1:0]          head_data;

  assign in_ready = (count != (PtrW+1)'(DEPTH));
  // rd 0 handshakes normally but never occupies a slot.
  assign push     = in_valid && in_ready && (in_rd != '0);
  // Pop decision uses the pre-edge count, so a push into an empty queue waits a cycle.
  assign pop      = (count != '0);
  assign pending  = count;

`ifdef WB_FWD_EN
  logic [PtrW-1:0]       head_ptr;
  wb_entry_t [DEPTH-1:0] entries;
`endif

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_rd   (in_rd),
    .push_data (in_data),
    .pop       (pop),
    .head_rd   (head_rd),
    .head_data (head_data),
`ifdef WB_FWD_EN
    .head_ptr  (head_ptr),
    .entries   (entries),
`endif
    .count     (count)
  );

  // Output register: address/data hold when no entry retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write  <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
    end else begin
      reg_write <= pop;
      if (pop) begin
        write_addr <= head_rd;
        write_data <= head_data;
      end
    end
  end

`ifdef WB_FWD_EN
  // Output register is oldest; stored entries are scanned head to tail so the
  // youngest match overwrites earlier ones.
  function automatic fwd_result_t fwd_lookup(
    input logic [`RFIDX_WIDTH-1:0] addr,
    input wb_entry_t [DEPTH-1:0]   ents,
    input logic [PtrW-1:0]         head,
    input logic [PtrW:0]           cnt,
    input logic                    out_vld,
    input logic [`RFIDX_WIDTH-1:0] out_addr,
    input logic [`XLEN-1:0]        out_data
  );
    fwd_result_t     r;
    logic [PtrW-1:0] idx;
    r = '0;
    if (addr != '0) begin
      if (out_vld && (out_addr == addr)) begin
        r.hit  = 1'b1;
        r.data = out_data;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        idx = head + PtrW'(i);
        if (((PtrW+1)'(i) < cnt) && (ents[idx].rd == addr)) begin
          r.hit  = 1'b1;
          r.data = ents[idx].data;
        end
      end
    end
    return r;
  endfunction

  fwd_result_t res1, res2;

  always_comb begin
    res1 = fwd_lookup(fwd_addr1, entries, head_ptr, count, reg_write, write_addr, write_data);
    res2 = fwd_lookup(fwd_addr2, entries, head_ptr, count, reg_write, write_addr, write_data);
  end

  assign fwd_hit1  = res1.hit;
  assign fwd_data1 = res1.data;
  assign fwd_hit2  = res2.hit;
  assign fwd_data2 = res2.data;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: directed scenarios plus randomized traffic, all checked
// against a queue-based reference model.
module tb_wb_queue;
  import wb_queue_pkg::*;

  localparam int unsigned DEPTH = WB_DEPTH_DEFAULT;
  localparam int unsigned PW    = $clog2(DEPTH);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [RFIDX_W-1:0] in_rd = '0;
  logic [XLEN-1:0]    in_data = '0;
  logic               reg_write;
  logic [RFIDX_W-1:0] write_addr;
  logic [XLEN-1:0]    write_data;
  logic [PW:0]        pending;
`ifdef WB_FWD_EN
  logic [RFIDX_W-1:0] fwd_addr1 = '0, fwd_addr2 = '0;
  logic               fwd_hit1, fwd_hit2;
  logic [XLEN-1:0]    fwd_data1, fwd_data2;
`endif

  always #5 clk = ~clk;

  wb_queue #(
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rd      (in_rd),
    .in_data    (in_data),
    .reg_write  (reg_write),
    .write_addr (write_addr),
    .write_data (write_data),
`ifdef WB_FWD_EN
    .fwd_addr1  (fwd_addr1),
    .fwd_addr2  (fwd_addr2),
    .fwd_hit1   (fwd_hit1),
    .fwd_hit2   (fwd_hit2),
    .fwd_data1  (fwd_data1),
    .fwd_data2  (fwd_data2),
`endif
    .pending    (pending)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending writes in acceptance order plus the write port.
  wb_entry_t          mq[$];
  logic               m_rw = 1'b0;
  logic [RFIDX_W-1:0] m_addr = '0;
  logic [XLEN-1:0]    m_data = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

`ifdef WB_FWD_EN
  task automatic model_fwd(input logic [RFIDX_W-1:0] a, output logic hit,
                           output logic [XLEN-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (a != '0) begin
      if (m_rw && m_addr == a) begin
        hit = 1'b1;
        d   = m_data;
      end
      foreach (mq[i]) begin
        if (mq[i].rd == a) begin
          hit = 1'b1;
          d   = mq[i].data;
        end
      end
    end
  endtask
`endif

  task automatic compare_all();
`ifdef WB_FWD_EN
    logic h;
    logic [XLEN-1:0] d;
`endif
    check("in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
    check("pending", 64'(pending), 64'(mq.size()));
    check("reg_write", 64'(reg_write), 64'(m_rw));
    check("write_addr", 64'(write_addr), 64'(m_addr));
    check("write_data", 64'(write_data), 64'(m_data));
`ifdef WB_FWD_EN
    model_fwd(fwd_addr1, h, d);
    check("fwd_hit1", 64'(fwd_hit1), 64'(h));
    if (h) check("fwd_data1", 64'(fwd_data1), 64'(d));
    model_fwd(fwd_addr2, h, d);
    check("fwd_hit2", 64'(fwd_hit2), 64'(h));
    if (h) check("fwd_data2", 64'(fwd_data2), 64'(d));
`endif
  endtask

  // Edge behaviour: retire the oldest pending write if any existed before the
  // edge, then accept the offered result if there was room and rd is nonzero.
  task automatic model_edge();
    logic accept;
    wb_entry_t e;
    accept = in_valid && (mq.size() != DEPTH);
    if (mq.size() != 0) begin
      e      = mq.pop_front();
      m_rw   = 1'b1;
      m_addr = e.rd;
      m_data = e.data;
    end else begin
      m_rw = 1'b0;
    end
    if (accept && in_rd != '0) mq.push_back('{rd: in_rd, data: in_data});
  endtask

  task automatic step(input logic v, input logic [RFIDX_W-1:0] rd, input logic [XLEN-1:0] d);
    in_valid = v;
    in_rd    = rd;
    in_data  = d;
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    // Reset state, sampled while reset is held.
    #2;
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_reg_write", 64'(reg_write), 64'd0);
    check("rst_write_addr", 64'(write_addr), 64'd0);
    check("rst_write_data", 64'(write_data), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Single write: pulse appears one cycle after the accept edge.
    step(1'b1, 5'd5, 32'h1234);
    check("single_rw_accept", 64'(reg_write), 64'd0);
    check("single_pending", 64'(pending), 64'd1);
    step(1'b0, 5'd0, 32'h0);
    check("single_rw", 64'(reg_write), 64'd1);
    check("single_addr", 64'(write_addr), 64'd5);
    check("single_data", 64'(write_data), 64'h1234);
    step(1'b0, 5'd0, 32'h0);
    check("single_rw_drop", 64'(reg_write), 64'd0);
    check("single_addr_hold", 64'(write_addr), 64'd5);

    // Back-to-back pushes rd=1..5, retirement order checked by the model.
    for (int i = 1; i <= 5; i++) step(1'b1, RFIDX_W'(i), XLEN'(32'h100 + i));
    for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 32'h0);

    // x0 result is accepted but never written.
    step(1'b1, 5'd0, 32'hFFFF);
    check("x0_pending", 64'(pending), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 5'd0, 32'h0);
      check("x0_no_write", 64'(reg_write), 64'd0);
    end

    // Reset mid-flight drops everything in the queue and the write port.
    step(1'b1, 5'd9, 32'h9);
    step(1'b1, 5'd10, 32'hA0);
    step(1'b1, 5'd11, 32'hB0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midrst_pending", 64'(pending), 64'd0);
    check("midrst_reg_write", 64'(reg_write), 64'd0);
    check("midrst_write_addr", 64'(write_addr), 64'd0);
    check("midrst_write_data", 64'(write_data), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    #4;
    rst_n = 1'b1;
    mq.delete();
    m_rw   = 1'b0;
    m_addr = '0;
    m_data = '0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 5'd0, 32'h0);
      check("midrst_no_write", 64'(reg_write), 64'd0);
    end

    // Continuous traffic wrapping the pointers.
    for (int i = 0; i < 10; i++) step(1'b1, RFIDX_W'(i + 1), $urandom);
    for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 32'h0);

`ifdef WB_FWD_EN
    // Youngest match wins over the output register.
    fwd_addr1 = 5'd7;
    fwd_addr2 = 5'd0;
    step(1'b1, 5'd7, 32'hA);
    step(1'b1, 5'd7, 32'hB);
    check("fwd_dir_hit1", 64'(fwd_hit1), 64'd1);
    check("fwd_dir_data1", 64'(fwd_data1), 64'hB);
    check("fwd_dir_hit2", 64'(fwd_hit2), 64'd0);
    step(1'b0, 5'd0, 32'h0);
    step(1'b0, 5'd0, 32'h0);
`endif

    // Randomized traffic with a small index range to provoke matches.
    for (int i = 0; i < 400; i++) begin
`ifdef WB_FWD_EN
      fwd_addr1 = RFIDX_W'($urandom_range(0, 7));
      fwd_addr2 = RFIDX_W'($urandom_range(0, 7));
`endif
      step($urandom_range(0, 3) != 0, RFIDX_W'($urandom_range(0, 7)), $urandom);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
